// File: rtl/strip_digest_beat_if.sv
// Stream bundle for strip_digest_beat: input packet, payload output and digest output.
interface strip_digest_beat_if #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned ID_W   = 6,
    parameter int unsigned CNT_W  = 16
);
    // Input packet stream
    logic [DATA_W-1:0] inp_data;
    logic [KEEP_W-1:0] inp_keep;
    logic [ID_W-1:0]   inp_id;
    logic              inp_last;
    logic              inp_valid;
    logic              inp_ready;

    // Payload stream (digest beat removed)
    logic [DATA_W-1:0] out;
    logic [KEEP_W-1:0] out_keep;
    logic [ID_W-1:0]   out_id;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    // Digest stream
    logic [DATA_W-1:0] dig_data;
    logic [KEEP_W-1:0] dig_keep;
    logic [ID_W-1:0]   dig_id;
    logic [CNT_W-1:0]  dig_beats;
    logic              dig_valid;
    logic              dig_ready;

    // Environment side: sources packets, sinks payload and digest
    modport master (
        output inp_data, inp_keep, inp_id, inp_last, inp_valid,
        input  inp_ready,
        input  out, out_keep, out_id, out_last, out_valid,
        output out_ready,
        input  dig_data, dig_keep, dig_id, dig_beats, dig_valid,
        output dig_ready
    );

    // Block side
    modport slave (
        input  inp_data, inp_keep, inp_id, inp_last, inp_valid,
        output inp_ready,
        output out, out_keep, out_id, out_last, out_valid,
        input  out_ready,
        output dig_data, dig_keep, dig_id, dig_beats, dig_valid,
        input  dig_ready
    );
endinterface

// File: rtl/strip_digest_beat.sv
// Splits a packet whose final beat is a digest into a payload stream (last moved
// one beat earlier) and a digest stream carrying the digest plus payload beat count.
module strip_digest_beat #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned ID_W   = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    strip_digest_beat_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [DATA_W-1:0] h_data;
    logic [KEEP_W-1:0] h_keep;
    logic [ID_W-1:0]   h_id;

    logic [DATA_W-1:0] d_data;
    logic [KEEP_W-1:0] d_keep;
    logic [ID_W-1:0]   d_id;
    logic [CNT_W-1:0]  d_beats;
    logic              dv;

    logic [CNT_W-1:0]  cnt;

    logic              dspace_c;
    logic              inp_ready_c;
    logic              out_valid_c;
    logic              out_last_c;
    logic              load_h_c;
    logic              load_d_c;

    // Digest register can take a new beat if empty or draining this cycle
    assign dspace_c = !dv || bus.dig_ready;

    // Phase register: EMPTY or HOLD (one payload beat parked in H)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next phase, handshakes and load strobes
    always_comb begin
        state_nx    = state;
        inp_ready_c = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        load_h_c    = 1'b0;
        load_d_c    = 1'b0;
        case (state)
            S_EMPTY: begin
                if (bus.inp_valid && bus.inp_last) begin
                    // digest-only packet: nothing to emit on the payload side
                    inp_ready_c = dspace_c;
                    load_d_c    = dspace_c;
                end else begin
                    inp_ready_c = 1'b1;
                    if (bus.inp_valid) begin
                        load_h_c = 1'b1;
                        state_nx = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.inp_valid && bus.inp_last) begin
                    // held beat closes the payload; digest must land at the same time
                    out_valid_c = dspace_c;
                    out_last_c  = 1'b1;
                    inp_ready_c = bus.out_ready && dspace_c;
                    if (bus.out_ready && dspace_c) begin
                        load_d_c = 1'b1;
                        state_nx = S_EMPTY;
                    end
                end else begin
                    // held beat is not the last payload beat once another body beat shows
                    out_valid_c = bus.inp_valid;
                    inp_ready_c = bus.out_ready;
                    load_h_c    = bus.inp_valid && bus.out_ready;
                end
            end
            default: begin
                state_nx = S_EMPTY;
            end
        endcase
    end

    // Hold buffer and saturating payload beat counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_data <= '0;
            h_keep <= '0;
            h_id   <= '0;
            cnt    <= '0;
        end else if (load_h_c) begin
            h_data <= bus.inp_data;
            h_keep <= bus.inp_keep;
            h_id   <= bus.inp_id;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (load_d_c) begin
            cnt <= '0;
        end
    end

    // Digest register: captured on a last beat, released on dig handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_data  <= '0;
            d_keep  <= '0;
            d_id    <= '0;
            d_beats <= '0;
            dv      <= 1'b0;
        end else if (load_d_c) begin
            d_data  <= bus.inp_data;
            d_keep  <= bus.inp_keep;
            d_id    <= bus.inp_id;
            d_beats <= cnt;
            dv      <= 1'b1;
        end else if (dv && bus.dig_ready) begin
            dv      <= 1'b0;
        end
    end

    // Output drive; payload bus is zeroed while not valid
    assign bus.inp_ready = inp_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.out       = out_valid_c ? h_data : '0;
    assign bus.out_keep  = out_valid_c ? h_keep : '0;
    assign bus.out_id    = out_valid_c ? h_id   : '0;

    assign bus.dig_valid = dv;
    assign bus.dig_data  = d_data;
    assign bus.dig_keep  = d_keep;
    assign bus.dig_id    = d_id;
    assign bus.dig_beats = d_beats;

endmodule

// File: tb/tb_strip_digest_beat.sv
// Directed bench for strip_digest_beat: payload/digest split, stalls, reset abort, saturation.
module tb_strip_digest_beat;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned KEEP_W = 64;
    localparam int unsigned ID_W   = 6;
    localparam int unsigned CNT_W  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    strip_digest_beat_if #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W), .CNT_W(CNT_W)
    ) bus ();

    strip_digest_beat #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W), .CNT_W(CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DATA_W-1:0] out_d_q[$];
    logic              out_l_q[$];
    int                out_c_q[$];
    logic [DATA_W-1:0] dig_d_q[$];
    logic [CNT_W-1:0]  dig_b_q[$];
    logic [KEEP_W-1:0] dig_k_q[$];
    logic [ID_W-1:0]   dig_i_q[$];
    int                dig_c_q[$];

    // Cycle counter
    always @(posedge clock) cyc <= cyc + 1;

    // Record every handshake that the next rising edge will complete
    always @(negedge clock) begin
        if (reset) begin
            if (bus.out_valid && bus.out_ready) begin
                out_d_q.push_back(bus.out);
                out_l_q.push_back(bus.out_last);
                out_c_q.push_back(cyc);
            end
            if (bus.dig_valid && bus.dig_ready) begin
                dig_d_q.push_back(bus.dig_data);
                dig_b_q.push_back(bus.dig_beats);
                dig_k_q.push_back(bus.dig_keep);
                dig_i_q.push_back(bus.dig_id);
                dig_c_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [7:0] d);
        return DATA_W'(d) | (DATA_W'(d) << 256);
    endfunction

    function automatic logic [KEEP_W-1:0] kpat(input logic [7:0] d);
        return KEEP_W'({8{d}});
    endfunction

    task automatic drive(input logic [7:0] d, input logic last);
        bus.inp_data  = pat(d);
        bus.inp_keep  = kpat(d);
        bus.inp_id    = ID_W'(d);
        bus.inp_last  = last;
        bus.inp_valid = 1'b1;
    endtask

    // Present a beat and wait (bounded) for it to be accepted
    task automatic send(input logic [7:0] d, input logic last);
        logic done;
        done = 1'b0;
        drive(d, last);
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            done = bus.inp_ready;
            @(posedge clock);
            #1;
        end
        if (!done) check("send_timeout", DATA_W'(done), DATA_W'(1));
    endtask

    task automatic idle(input int n);
        bus.inp_valid = 1'b0;
        bus.inp_last  = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob;
        int db;
        int ob2;
        bus.inp_valid = 1'b0;
        bus.inp_last  = 1'b0;
        bus.inp_data  = '0;
        bus.inp_keep  = '0;
        bus.inp_id    = '0;
        bus.out_ready = 1'b1;
        bus.dig_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", DATA_W'(bus.out_valid), DATA_W'(0));
        check("rst_dig_valid", DATA_W'(bus.dig_valid), DATA_W'(0));
        check("rst_inp_ready", DATA_W'(bus.inp_ready), DATA_W'(1));
        check("rst_out",       bus.out,                DATA_W'(0));
        check("rst_dig_data",  bus.dig_data,           DATA_W'(0));
        check("rst_dig_beats", DATA_W'(bus.dig_beats), DATA_W'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(1);

        // 4-beat packet, readies high
        ob = out_d_q.size();
        db = dig_d_q.size();
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b1);
        idle(4);
        check("t1_out_cnt", DATA_W'(out_d_q.size() - ob), DATA_W'(3));
        if (out_d_q.size() >= ob + 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t1_out_data", out_d_q[ob+i], pat(8'(8'hA1 + i)));
                check("t1_out_last", DATA_W'(out_l_q[ob+i]), DATA_W'(i == 2));
            end
            check("t1_b2b_0", DATA_W'(out_c_q[ob+1] - out_c_q[ob]), DATA_W'(1));
            check("t1_b2b_1", DATA_W'(out_c_q[ob+2] - out_c_q[ob+1]), DATA_W'(1));
        end
        check("t1_dig_cnt", DATA_W'(dig_d_q.size() - db), DATA_W'(1));
        if (dig_d_q.size() > db && out_c_q.size() >= ob + 3) begin
            check("t1_dig_data",  dig_d_q[db],          pat(8'hA4));
            check("t1_dig_beats", DATA_W'(dig_b_q[db]), DATA_W'(3));
            check("t1_dig_keep",  DATA_W'(dig_k_q[db]), DATA_W'(kpat(8'hA4)));
            check("t1_dig_id",    DATA_W'(dig_i_q[db]), DATA_W'(ID_W'(8'hA4)));
            check("t1_dig_lat",   DATA_W'(dig_c_q[db] - out_c_q[ob+2]), DATA_W'(1));
        end

        // Digest-only packet
        ob = out_d_q.size();
        db = dig_d_q.size();
        send(8'hB0, 1'b1);
        idle(3);
        check("t2_out_cnt", DATA_W'(out_d_q.size() - ob), DATA_W'(0));
        check("t2_dig_cnt", DATA_W'(dig_d_q.size() - db), DATA_W'(1));
        if (dig_d_q.size() > db) begin
            check("t2_dig_data",  dig_d_q[db],          pat(8'hB0));
            check("t2_dig_beats", DATA_W'(dig_b_q[db]), DATA_W'(0));
        end

        // 3-beat packet, out_ready 1,0,0,1
        ob = out_d_q.size();
        db = dig_d_q.size();
        drive(8'hC1, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("t3_rdy_c1", DATA_W'(bus.inp_ready), DATA_W'(1));
        @(posedge clock);
        #1;
        drive(8'hC2, 1'b0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("t3_stall_rdy",   DATA_W'(bus.inp_ready), DATA_W'(0));
            check("t3_stall_valid", DATA_W'(bus.out_valid), DATA_W'(1));
            check("t3_stall_out",   bus.out,                pat(8'hC1));
            check("t3_stall_keep",  DATA_W'(bus.out_keep),  DATA_W'(kpat(8'hC1)));
            check("t3_stall_id",    DATA_W'(bus.out_id),    DATA_W'(ID_W'(8'hC1)));
            @(posedge clock);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("t3_rdy_resume", DATA_W'(bus.inp_ready), DATA_W'(1));
        @(posedge clock);
        #1;
        send(8'hC3, 1'b1);
        idle(3);
        check("t3_out_cnt", DATA_W'(out_d_q.size() - ob), DATA_W'(2));
        if (out_d_q.size() >= ob + 2) begin
            check("t3_out0", out_d_q[ob],   pat(8'hC1));
            check("t3_last0", DATA_W'(out_l_q[ob]), DATA_W'(0));
            check("t3_out1", out_d_q[ob+1], pat(8'hC2));
            check("t3_last1", DATA_W'(out_l_q[ob+1]), DATA_W'(1));
        end
        check("t3_dig_cnt", DATA_W'(dig_d_q.size() - db), DATA_W'(1));
        if (dig_d_q.size() > db) begin
            check("t3_dig_data",  dig_d_q[db],          pat(8'hC3));
            check("t3_dig_beats", DATA_W'(dig_b_q[db]), DATA_W'(2));
        end

        // Two 2-beat packets with dig_ready held low
        ob = out_d_q.size();
        db = dig_d_q.size();
        bus.dig_ready = 1'b0;
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b1);
        send(8'hF1, 1'b0);
        drive(8'hF2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t4_stall_rdy",   DATA_W'(bus.inp_ready), DATA_W'(0));
            check("t4_stall_out_v", DATA_W'(bus.out_valid), DATA_W'(0));
            check("t4_stall_dig_v", DATA_W'(bus.dig_valid), DATA_W'(1));
            @(posedge clock);
            #1;
        end
        bus.dig_ready = 1'b1;
        @(negedge clock);
        check("t4_release_rdy", DATA_W'(bus.inp_ready), DATA_W'(1));
        @(posedge clock);
        #1;
        idle(3);
        check("t4_dig_cnt", DATA_W'(dig_d_q.size() - db), DATA_W'(2));
        if (dig_d_q.size() >= db + 2) begin
            check("t4_dig0",   dig_d_q[db],            pat(8'hE2));
            check("t4_beats0", DATA_W'(dig_b_q[db]),   DATA_W'(1));
            check("t4_dig1",   dig_d_q[db+1],          pat(8'hF2));
            check("t4_beats1", DATA_W'(dig_b_q[db+1]), DATA_W'(1));
        end
        check("t4_out_cnt", DATA_W'(out_d_q.size() - ob), DATA_W'(2));
        if (out_d_q.size() >= ob + 2) begin
            check("t4_out0",  out_d_q[ob],            pat(8'hE1));
            check("t4_last0", DATA_W'(out_l_q[ob]),   DATA_W'(1));
            check("t4_out1",  out_d_q[ob+1],          pat(8'hF1));
            check("t4_last1", DATA_W'(out_l_q[ob+1]), DATA_W'(1));
        end

        // Reset in the middle of a packet, then a fresh 2-beat packet
        db = dig_d_q.size();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        bus.inp_valid = 1'b0;
        bus.inp_last  = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("t5_rst_out_v", DATA_W'(bus.out_valid), DATA_W'(0));
        check("t5_rst_dig_v", DATA_W'(bus.dig_valid), DATA_W'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(1);
        ob2 = out_d_q.size();
        send(8'h71, 1'b0);
        send(8'h72, 1'b1);
        idle(3);
        check("t5_out_cnt", DATA_W'(out_d_q.size() - ob2), DATA_W'(1));
        if (out_d_q.size() > ob2) begin
            check("t5_out0",  out_d_q[ob2],          pat(8'h71));
            check("t5_last0", DATA_W'(out_l_q[ob2]), DATA_W'(1));
        end
        check("t5_dig_cnt", DATA_W'(dig_d_q.size() - db), DATA_W'(1));
        if (dig_d_q.size() > db) begin
            check("t5_dig_data",  dig_d_q[db],          pat(8'h72));
            check("t5_dig_beats", DATA_W'(dig_b_q[db]), DATA_W'(1));
        end

        // 20-beat packet: counter saturates at 15
        ob = out_d_q.size();
        db = dig_d_q.size();
        for (int i = 0; i < 20; i++) begin
            send(8'(8'h40 + i), i == 19);
        end
        idle(3);
        check("t6_out_cnt", DATA_W'(out_d_q.size() - ob), DATA_W'(19));
        if (out_d_q.size() >= ob + 19) begin
            for (int i = 0; i < 19; i++) begin
                check("t6_out_data", out_d_q[ob+i], pat(8'(8'h40 + i)));
                check("t6_out_last", DATA_W'(out_l_q[ob+i]), DATA_W'(i == 18));
            end
        end
        check("t6_dig_cnt", DATA_W'(dig_d_q.size() - db), DATA_W'(1));
        if (dig_d_q.size() > db) begin
            check("t6_dig_data",  dig_d_q[db],          pat(8'h53));
            check("t6_dig_beats", DATA_W'(dig_b_q[db]), DATA_W'(15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
